// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES sequencer types: block/key words, FSM states,
// round counts per key size and the round-key index mapping.
package aes_round_sequencer_pkg;

   typedef logic [127:0] state_t;
   typedef logic [127:0] roundkey_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } seq_state_t;

   localparam int AES128_ROUNDS = 10;
   localparam int AES192_ROUNDS = 12;
   localparam int AES256_ROUNDS = 14;

   // Decryption walks the key schedule from the top down.
   function automatic logic [3:0] key_index(
      input logic [3:0] rnd,
      input logic       dec,
      input logic [3:0] nr
   );
      return dec ? (nr - rnd) : rnd;
   endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-level valid/ready handshake between a client and the
// AES round sequencer.
interface aes_round_sequencer_if;
   import aes_round_sequencer_pkg::*;

   logic   in_valid;
   logic   in_ready;
   state_t in_data;
   logic   in_decrypt;
   logic   out_valid;
   logic   out_ready;
   state_t out_data;

   modport master (
      output in_valid, in_data, in_decrypt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_decrypt, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: initial AddRoundKey, then one round
// per pass through an external shared round datapath.
module aes_round_sequencer
   import aes_round_sequencer_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int DP_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   aes_round_sequencer_if.slave  blk,
   output logic                  busy,
   output logic [3:0]            key_idx,
   input  roundkey_t             key_data,
   output state_t                dp_in,
   output roundkey_t             dp_key,
   output logic                  dp_inverse,
   output logic                  dp_final,
   input  state_t                dp_out
);

   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam int WW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
   localparam logic [RW-1:0] LAST  = RW'(NUM_ROUNDS);
   localparam logic [WW-1:0] WLOAD = WW'(DP_LATENCY - 1);
   localparam logic [3:0]    NR    = 4'(NUM_ROUNDS);

   seq_state_t    fsm, fsm_n;
   state_t        st, st_n;
   state_t        od, od_n;
   logic [RW-1:0] rnd, rnd_n;
   logic [WW-1:0] wcnt, wcnt_n;
   logic          mode, mode_n;
   logic          active;
   logic          last;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm  <= IDLE;
         st   <= '0;
         od   <= '0;
         rnd  <= '0;
         wcnt <= '0;
         mode <= 1'b0;
      end else begin
         fsm  <= fsm_n;
         st   <= st_n;
         od   <= od_n;
         rnd  <= rnd_n;
         wcnt <= wcnt_n;
         mode <= mode_n;
      end
   end

   always_comb begin
      fsm_n  = fsm;
      st_n   = st;
      od_n   = od;
      rnd_n  = rnd;
      wcnt_n = wcnt;
      mode_n = mode;
      unique case (fsm)
         IDLE: begin
            if (blk.in_valid) begin
               mode_n = blk.in_decrypt;
               st_n   = blk.in_data ^ key_data;
               rnd_n  = RW'(1);
               fsm_n  = ISSUE;
            end
         end
         ISSUE: begin
            wcnt_n = WLOAD;
            fsm_n  = WAIT;
         end
         WAIT: begin
            if (wcnt == '0) begin
               st_n = dp_out;
               if (last) begin
                  od_n  = dp_out;
                  fsm_n = DONE;
               end else begin
                  rnd_n = rnd + RW'(1);
                  fsm_n = ISSUE;
               end
            end else begin
               wcnt_n = wcnt - WW'(1);
            end
         end
         DONE: begin
            if (blk.out_ready) fsm_n = IDLE;
         end
         default: fsm_n = IDLE;
      endcase
   end

   assign active = (fsm == ISSUE) || (fsm == WAIT);
   assign last   = (rnd == LAST);

   assign blk.in_ready  = (fsm == IDLE);
   assign blk.out_valid = (fsm == DONE);
   assign blk.out_data  = od;
   assign busy          = (fsm != IDLE);

   // In IDLE the index tracks the requested direction so the
   // whitening key is present on the accept edge.
   assign key_idx = (fsm == IDLE)
                  ? key_index(4'd0, blk.in_decrypt, NR)
                  : key_index(4'(rnd), mode, NR);

   assign dp_in      = st;
   assign dp_key     = key_data;
   assign dp_inverse = active & mode;
   assign dp_final   = active & last;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES round datapath and key
// schedule models, FIPS-197 vectors plus random blocks.
module tb_aes_round_sequencer;
   import aes_round_sequencer_pkg::*;

   localparam int NR = 10;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   aes_round_sequencer_if bif();

   logic       busy;
   logic [3:0] key_idx;
   state_t     key_data;
   state_t     dp_in;
   roundkey_t  dp_key;
   logic       dp_inverse;
   logic       dp_final;
   state_t     dp_out;

   logic [7:0]   sb[256];
   logic [7:0]   isb[256];
   logic [127:0] rk[16];
   logic [127:0] dp_q;
   logic [5:0]   trace[$];

   int n_chk  = 0;
   int n_pass = 0;

   aes_round_sequencer #(
      .NUM_ROUNDS(NR),
      .DP_LATENCY(1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .blk        (bif),
      .busy       (busy),
      .key_idx    (key_idx),
      .key_data   (key_data),
      .dp_in      (dp_in),
      .dp_key     (dp_key),
      .dp_inverse (dp_inverse),
      .dp_final   (dp_final),
      .dp_out     (dp_out)
   );

   function automatic logic [7:0] xt(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(logic [7:0] b, int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic gen_tables();
      logic [7:0] v, inv, s;
      for (int x = 0; x < 256; x++) begin
         v   = 8'(x);
         inv = 8'h01;
         if (x == 0) inv = 8'h00;
         else for (int k = 0; k < 254; k++) inv = gm(inv, v);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sb[x]  = s;
         isb[s] = v;
      end
   endtask

   function automatic logic [127:0] enc_round(logic [127:0] s, logic [127:0] k, logic fin);
      logic [7:0]   a[16];
      logic [7:0]   t[16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            a[4*c]   = gm(t[4*c], 8'd2) ^ gm(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
            a[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'd2) ^ gm(t[4*c+2], 8'd3) ^ t[4*c+3];
            a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'd2) ^ gm(t[4*c+3], 8'd3);
            a[4*c+3] = gm(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'd2);
         end
      end else a = t;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
      return o ^ k;
   endfunction

   function automatic logic [127:0] inv_round(logic [127:0] s, logic [127:0] k, logic fin);
      logic [7:0]   a[16];
      logic [7:0]   t[16];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r+4*c] = isb[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      o = o ^ k;
      if (!fin) begin
         for (int i = 0; i < 16; i++) a[i] = o[127-8*i -: 8];
         for (int c = 0; c < 4; c++) begin
            t[4*c]   = gm(a[4*c], 8'd14) ^ gm(a[4*c+1], 8'd11) ^ gm(a[4*c+2], 8'd13) ^ gm(a[4*c+3], 8'd9);
            t[4*c+1] = gm(a[4*c], 8'd9) ^ gm(a[4*c+1], 8'd14) ^ gm(a[4*c+2], 8'd11) ^ gm(a[4*c+3], 8'd13);
            t[4*c+2] = gm(a[4*c], 8'd13) ^ gm(a[4*c+1], 8'd9) ^ gm(a[4*c+2], 8'd14) ^ gm(a[4*c+3], 8'd11);
            t[4*c+3] = gm(a[4*c], 8'd11) ^ gm(a[4*c+1], 8'd13) ^ gm(a[4*c+2], 8'd9) ^ gm(a[4*c+3], 8'd14);
         end
         for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      end
      return o;
   endfunction

   task automatic load_keys(input logic [127:0] key);
      logic [31:0] w[44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k < 16; k++)
         rk[k] = (k <= NR) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
   endtask

   // Whole-block reference cipher over the loaded key schedule.
   function automatic logic [127:0] aes_ref(logic [127:0] x, logic dec);
      logic [127:0] s;
      if (!dec) begin
         s = x ^ rk[0];
         for (int r = 1; r <= NR; r++) s = enc_round(s, rk[r], r == NR);
      end else begin
         s = x ^ rk[NR];
         for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
      end
      return s;
   endfunction

   assign key_data = rk[key_idx];
   assign dp_out   = dp_q;

   always @(posedge clock)
      dp_q <= dp_inverse ? inv_round(dp_in, dp_key, dp_final)
                         : enc_round(dp_in, dp_key, dp_final);

   always @(negedge clock)
      if (reset && busy && !bif.out_valid)
         trace.push_back({dp_final, dp_inverse, key_idx});

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_block(
      input  string        tag,
      input  logic [127:0] din,
      input  logic         dec,
      input  logic [127:0] exp,
      output logic [127:0] res
   );
      int lat;
      int bad;
      int r;
      logic [3:0] ix;
      logic [5:0] e;
      bif.in_valid   = 1'b1;
      bif.in_data    = din;
      bif.in_decrypt = dec;
      #1;
      chk({tag, ".rdy"}, 128'(bif.in_ready), 128'(1));
      chk({tag, ".k0"}, 128'(key_idx), dec ? 128'(NR) : 128'(0));
      trace.delete();
      tick();
      bif.in_valid = 1'b0;
      lat = 0;
      while (!bif.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, ".lat"}, 128'(lat), 128'(2 * NR));
      chk({tag, ".out"}, bif.out_data, exp);
      res = bif.out_data;
      bad = 0;
      if (trace.size() != 2 * NR) bad++;
      else begin
         for (int i = 0; i < 2 * NR; i++) begin
            r  = i / 2 + 1;
            ix = dec ? 4'(NR - r) : 4'(r);
            e  = {(r == NR), dec, ix};
            if (trace[i] !== e) bad++;
         end
      end
      chk({tag, ".seq"}, 128'(bad), 128'(0));
      if (bif.out_ready) begin
         tick();
         chk({tag, ".drop"}, 128'({bif.out_valid, bif.in_ready, busy}), 128'(3'b010));
      end
   endtask

   initial begin
      logic [127:0] res, res2, pt, pb, ra, rb, hold;
      logic         dec;
      int           e, ov_e, acc_e, n;

      reset          = 1'b1;
      bif.in_valid   = 1'b0;
      bif.in_data    = '0;
      bif.in_decrypt = 1'b0;
      bif.out_ready  = 1'b1;
      gen_tables();
      load_keys(128'h2B7E151628AED2A6ABF7158809CF4F3C);
      #1 reset = 1'b0;
      #2;
      chk("rst.in_ready", 128'(bif.in_ready), 128'(1));
      chk("rst.out_valid", 128'(bif.out_valid), 128'(0));
      chk("rst.busy", 128'(busy), 128'(0));
      chk("rst.out_data", bif.out_data, 128'(0));
      chk("rst.key_idx", 128'(key_idx), 128'(0));
      chk("rst.dp_flags", 128'({dp_final, dp_inverse}), 128'(0));
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      tick();

      run_block("fipsB", 128'h3243F6A8885A308D313198A2E0370734, 1'b0,
                128'h3925841D02DC09FBDC118597196A0B32, res);
      load_keys(128'h000102030405060708090A0B0C0D0E0F);
      run_block("c1enc", 128'h00112233445566778899AABBCCDDEEFF, 1'b0,
                128'h69C4E0D86A7B0430D8CDB78070B4C55A, res);
      run_block("c1dec", 128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b1,
                128'h00112233445566778899AABBCCDDEEFF, res);

      for (int b = 0; b < 5; b++) begin
         load_keys({$urandom, $urandom, $urandom, $urandom});
         pt  = {$urandom, $urandom, $urandom, $urandom};
         dec = 1'($urandom_range(0, 1));
         run_block("rnd", pt, dec, aes_ref(pt, dec), res);
         run_block("rtrip", res, !dec, pt, res2);
      end

      // Backpressure with a competing offer held on the input.
      pt = {$urandom, $urandom, $urandom, $urandom};
      bif.out_ready = 1'b0;
      run_block("bp", pt, 1'b0, aes_ref(pt, 1'b0), hold);
      bif.in_valid = 1'b1;
      bif.in_data  = ~pt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp.data", bif.out_data, hold);
         chk("bp.hs", 128'({bif.out_valid, bif.in_ready}), 128'(2'b10));
      end
      bif.out_ready = 1'b1;
      tick();
      chk("bp.rel", 128'({bif.out_valid, bif.in_ready, busy}), 128'(3'b010));
      bif.in_valid = 1'b0;
      tick();
      chk("bp.noacc", 128'(busy), 128'(0));

      // Reset while round 5 is being issued.
      pt = {$urandom, $urandom, $urandom, $urandom};
      bif.in_valid   = 1'b1;
      bif.in_data    = pt;
      bif.in_decrypt = 1'b0;
      tick();
      bif.in_valid = 1'b0;
      repeat (9) tick();
      chk("mr.k5", 128'(key_idx), 128'(5));
      reset = 1'b0;
      #1;
      chk("mr.hs", 128'({bif.in_ready, bif.out_valid, busy, dp_final, dp_inverse}), 128'(5'b10000));
      chk("mr.data", bif.out_data, 128'(0));
      chk("mr.kidx", 128'(key_idx), 128'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      tick();
      chk("mr.idle", 128'(bif.out_valid), 128'(0));
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block("mr.new", pt, 1'b0, aes_ref(pt, 1'b0), res);

      // Two blocks with in_valid held high throughout.
      load_keys({$urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      pb = {$urandom, $urandom, $urandom, $urandom};
      bif.in_valid   = 1'b1;
      bif.in_data    = pt;
      bif.in_decrypt = 1'b0;
      tick();
      bif.in_data = pb;
      e = 0; ov_e = -1; acc_e = -1; ra = '0;
      while (e < 100 && acc_e < 0) begin
         tick();
         e++;
         if (bif.out_valid && ov_e < 0) begin
            ov_e = e;
            ra   = bif.out_data;
         end
         if (bif.in_ready && ov_e >= 0) acc_e = e + 1;
      end
      chk("b2b.gap", 128'(acc_e - ov_e), 128'(2));
      chk("b2b.a", ra, aes_ref(pt, 1'b0));
      tick();
      bif.in_valid = 1'b0;
      chk("b2b.acc", 128'(busy), 128'(1));
      n = 0;
      while (!bif.out_valid && n < 100) begin
         tick();
         n++;
      end
      rb = bif.out_data;
      chk("b2b.b", rb, aes_ref(pb, 1'b0));
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative controller that runs one 128-bit AES block through a single shared round datapath (BufferedRound / BufferedRoundInverse, selected by `dp_final` and `dp_inverse`), one round at a time.
- Performs the initial AddRoundKey itself and fetches round keys by index from an external key-schedule register file.
- Sequences rounds 1..NUM_ROUNDS, then returns the result over a valid/ready handshake.
- Sits between the block-level input/output interface and the round datapath.

Parameters:
- NUM_ROUNDS, 10, rounds per block (10/12/14 for AES-128/192/256).
- DP_LATENCY, 1, clock cycles from `dp_in`/`dp_key` to `dp_out` valid (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  128  plaintext (encrypt) or ciphertext (decrypt).
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  128  result block.
- busy  out  1  high in any state except IDLE.
- key_idx  out  4  round-key index; combinational from state.
- key_data  in  128  round key for `key_idx`, same cycle.
- dp_in  out  128  datapath state input.
- dp_key  out  128  datapath round key (= `key_data`).
- dp_inverse  out  1  select inverse datapath.
- dp_final  out  1  select last-round datapath (no MixColumns).
- dp_out  in  128  datapath result.

Behaviour:
- Reset (`reset`=0, async):
  - FSM goes to IDLE.
  - `in_ready`=1; `out_valid`=0; `busy`=0; `out_data`=0.
  - Internal state register=0, round counter=0, wait counter=0, mode=0.
  - `key_idx`=0; `dp_inverse`=0; `dp_final`=0.
  - A reset mid-block abandons the block silently; no output is produced.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`:
    - mode←`in_decrypt`.
    - State←`in_data` XOR `key_data`. Here `key_idx`=0 when `in_decrypt`=0, and `key_idx`=NUM_ROUNDS when `in_decrypt`=1; `key_idx` follows `in_decrypt` combinationally while in IDLE.
    - rnd←1, go to ISSUE.
- ISSUE:
  - Drives `dp_in`=state, `key_idx`=rnd (encrypt) or NUM_ROUNDS−rnd (decrypt).
  - Drives `dp_inverse`=mode, `dp_final`=(rnd==NUM_ROUNDS).
  - These outputs are held constant through the following WAIT cycles.
  - wait←DP_LATENCY−1 … go to WAIT.
- WAIT:
  - When wait==0, state←`dp_out`.
  - Then if rnd==NUM_ROUNDS: `out_data`←`dp_out`, go to DONE.
  - Otherwise rnd←rnd+1 and go to ISSUE.
  - If wait≠0, decrement wait.
- DONE:
  - `out_valid`=1; `out_data` stable; `in_ready`=0.
  - On `out_ready`, `out_valid` drops next cycle and the FSM returns to IDLE.
  - If `out_ready` is low, hold indefinitely (backpressure).
- Latency:
  - Accept edge E0 to `out_valid` high is NUM_ROUNDS×(DP_LATENCY+1) edges.
  - With defaults, `out_valid` is high after E20.
  - Throughput is one block per NUM_ROUNDS×(DP_LATENCY+1)+2 cycles minimum (accept, rounds, DONE→IDLE).
- No input is accepted outside IDLE. `in_ready` is combinational from the FSM state only; it never depends on `in_valid`.
- `out_ready` asserted while not in DONE is ignored.
- `key_idx` is always within 0..NUM_ROUNDS. The round counter width is $clog2(NUM_ROUNDS+1); 4 bits is sufficient up to 14 rounds.
- `dp_*` outputs outside ISSUE/WAIT are don't-care functionally but must be driven: `dp_in`=state, `dp_final`=0.

Decomposition:
- AESDefinitions package (shared):
  - `state_t` / `roundKey_t` (128-bit).
  - The `seq_state_t` enum {IDLE, ISSUE, WAIT, DONE}.
  - Constants for rounds per key size.
- The FSM is a single module. The round-key index mapping (encrypt/decrypt direction) is a small combinational function in the package.
- No sub-module; the datapath is instantiated outside by the parent.

Test Plan:
- Encrypt FIPS-197 Appendix B: `in_data`=3243F6A8885A308D313198A2E0370734, key schedule from 2B7E151628AED2A6ABF7158809CF4F3C → `out_data`=3925841D02DC09FBDC118597196A0B32, `out_valid` after exactly 20 edges.
- Encrypt FIPS-197 C.1: 00112233445566778899AABBCCDDEEFF, key 000102030405060708090A0B0C0D0E0F → 69C4E0D86A7B0430D8CDB78070B4C55A. Bench monitor checks `key_idx` sequence 0,1,…,10 and that `dp_final`=1 only for rnd 10.
- Decrypt C.1: 69C4E0D86A7B0430D8CDB78070B4C55A, `in_decrypt`=1 → 00112233445566778899AABBCCDDEEFF; `key_idx` sequence 10,9,…,0; `dp_inverse`=1 throughout.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `out_data` stable, `in_ready`=0, and a second `in_valid` is not accepted; release → `out_valid`=0 next cycle, `in_ready`=1.
- Reset mid-block: assert `reset`=0 at round 5 → outputs immediately at reset values. A new block after release produces the correct result with no stale output.
- Back-to-back: two blocks offered with `in_valid` continuously high and `out_ready`=1 → both results correct and in order; the second accept occurs exactly 2 cycles after the first `out_valid`.
